prog_loader: RTL

//  Upstream feeder for the cpu program-load port. Accepts a byte stream over a valid/ready handshake
//  and assembles big-endian 32-bit instruction words. Writes each word into instruction memory via

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_word_assembler.sv | 50 +++++
 rtl/prog_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program loader and its byte-to-word assembler.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StWord,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BytesPerWord = 4;

  // States in which the loader accepts a stream byte.
  function automatic logic takes_byte(state_e s);
    return s inside {StHdr0, StHdr1, StWord, StCsum};
  endfunction

  function automatic logic is_busy(state_e s);
    return !(s inside {StIdle, StDone, StErr});
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; also used for data-memory preload.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        full_q, full_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    full_d = full_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
      full_d = 1'b0;
    end else if (shift_i) begin
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[23:0], byte_i};
      full_d = (idx_q == 2'(BytesPerWord - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign last_o      = (idx_q == 2'(BytesPerWord - 1));
  assign word_o      = word_q;
  assign word_full_o = full_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a counted, checksummed frame of big-endian words into instruction memory,
// holding the cpu until the whole program has arrived intact.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        prog_en,
  output logic [31:0] inst_addr,
  output logic [31:0] prog_instruction,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_q, words_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        byte_ready_q, prog_en_q, cpu_hold_q, busy_q;

  logic        xfer;
  logic        asm_clear, asm_shift, asm_last, asm_full;
  logic [31:0] asm_word;

  word_assembler u_word_assembler (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (asm_clear),
    .shift_i    (asm_shift),
    .byte_i     (byte_in),
    .last_o     (asm_last),
    .word_o     (asm_word),
    .word_full_o(asm_full)
  );

  assign xfer = byte_valid & byte_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    words_d     = words_q;
    inst_addr_d = inst_addr_q;
    done_d      = done_q;
    err_d       = err_q;
    asm_clear   = 1'b0;
    asm_shift   = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d   = StHdr0;
          cnt_d     = 16'd0;
          csum_d    = 8'd0;
          words_d   = 16'd0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          asm_clear = 1'b1;
        end
      end
      StHdr0: begin
        if (xfer) begin
          cnt_d[15:8] = byte_in;
          state_d     = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          cnt_d[7:0] = byte_in;
          if (32'({cnt_q[15:8], byte_in}) > MAX_WORDS) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if ({cnt_q[15:8], byte_in} == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StWord;
          end
        end
      end
      StWord: begin
        if (xfer) begin
          asm_shift = 1'b1;
          csum_d    = csum_q ^ byte_in;
          if (asm_last) begin
            state_d     = StWrite;
            inst_addr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
          end
        end
      end
      StWrite: begin
        // The assembler always holds a complete word here; the flag just guards the exit.
        if (asm_full) begin
          words_d = words_q + 16'd1;
          state_d = ((words_q + 16'd1) == cnt_q) ? StCsum : StWord;
        end
      end
      StCsum: begin
        if (xfer) begin
          if (byte_in == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      csum_q       <= 8'd0;
      words_q      <= 16'd0;
      inst_addr_q  <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      prog_en_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      words_q      <= words_d;
      inst_addr_q  <= inst_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_ready_q <= takes_byte(state_d);
      prog_en_q    <= (state_d == StWrite);
      cpu_hold_q   <= (state_d != StDone);
      busy_q       <= is_busy(state_d);
    end
  end

  assign byte_ready       = byte_ready_q;
  assign prog_en          = prog_en_q;
  assign inst_addr        = inst_addr_q;
  assign prog_instruction = asm_word;
  assign cpu_hold         = cpu_hold_q;
  assign busy             = busy_q;
  assign load_done        = done_q;
  assign load_err         = err_q;
  assign words_loaded     = words_q;

endmodule
